// File: rtl/move_controller.sv
`default_nettype none
// ============================================================================
// Module   : move_controller
// Purpose  : Turn-based move arbiter for a 3x3 board: validates moves, writes
//            them to the board, waits for refresh, then scans for win/draw.
// Revision : 1.0 - initial release
// ============================================================================
module move_controller #(
  parameter int CELLS       = 9,
  parameter int STATE_W     = 2,
  parameter int INDEX_W     = 4,
  parameter int REF_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     new_game,
  input  logic                     move_valid,
  input  logic [INDEX_W-1:0]       move_loc,
  output logic                     move_ready,
  input  logic [CELLS*STATE_W-1:0] board_state,
  input  logic                     refresh,
  output logic [INDEX_W-1:0]       update_loc,
  output logic [STATE_W-1:0]       update_val,
  output logic                     submit,
  output logic                     board_reset,
  output logic [STATE_W-1:0]       turn,
  output logic                     reject,
  output logic                     game_over,
  output logic [STATE_W-1:0]       winner,
  output logic                     fault
);

  localparam int                 c_cnt_w  = $clog2(REF_TIMEOUT + 1);
  localparam logic [STATE_W-1:0] c_empty  = '0;
  localparam logic [STATE_W-1:0] c_x      = STATE_W'(1);
  localparam logic [STATE_W-1:0] c_o      = STATE_W'(2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_SUBMIT   = 3'd2,
    S_WAIT_REF = 3'd3,
    S_SCAN     = 3'd4,
    S_DONE     = 3'd5,
    S_CLEAR    = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [INDEX_W-1:0]   r_loc;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2:0]           r_line;
  logic [STATE_W-1:0]   r_turn;
  logic [STATE_W-1:0]   r_winner;
  logic                 r_game_over;
  logic                 r_fault;
  logic                 r_reject;
  logic                 r_submit;
  logic                 r_board_reset;
  logic [INDEX_W-1:0]   r_update_loc;
  logic [STATE_W-1:0]   r_update_val;

  logic                 w_latch;
  logic                 w_reject;
  logic                 w_load;
  logic                 w_timeout;
  logic                 w_win;
  logic                 w_draw;
  logic                 w_toggle;
  logic                 w_clear;
  logic                 w_illegal;
  logic                 w_line_win;
  logic                 w_any_empty;
  logic [3*INDEX_W-1:0] w_line_idx;

  // Constant-index mux keeps every board select in range for any index value.
  function automatic logic [STATE_W-1:0] cell_at(
    input logic [CELLS*STATE_W-1:0] b,
    input logic [INDEX_W-1:0]       idx
  );
    logic [STATE_W-1:0] v;
    v = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (idx == INDEX_W'(i)) v = b[i*STATE_W +: STATE_W];
    end
    return v;
  endfunction

  function automatic logic [3*INDEX_W-1:0] line_cells(input logic [2:0] line);
    logic [INDEX_W-1:0] a, b, c;
    case (line)
      3'd0:    begin a = INDEX_W'(0); b = INDEX_W'(1); c = INDEX_W'(2); end
      3'd1:    begin a = INDEX_W'(3); b = INDEX_W'(4); c = INDEX_W'(5); end
      3'd2:    begin a = INDEX_W'(6); b = INDEX_W'(7); c = INDEX_W'(8); end
      3'd3:    begin a = INDEX_W'(0); b = INDEX_W'(3); c = INDEX_W'(6); end
      3'd4:    begin a = INDEX_W'(1); b = INDEX_W'(4); c = INDEX_W'(7); end
      3'd5:    begin a = INDEX_W'(2); b = INDEX_W'(5); c = INDEX_W'(8); end
      3'd6:    begin a = INDEX_W'(0); b = INDEX_W'(4); c = INDEX_W'(8); end
      default: begin a = INDEX_W'(2); b = INDEX_W'(4); c = INDEX_W'(6); end
    endcase
    return {a, b, c};
  endfunction

  always_comb begin
    w_illegal   = (r_loc >= INDEX_W'(CELLS)) || (cell_at(board_state, r_loc) != c_empty);
    w_line_idx  = line_cells(r_line);
    w_line_win  = (cell_at(board_state, w_line_idx[3*INDEX_W-1:2*INDEX_W]) == r_turn) &&
                  (cell_at(board_state, w_line_idx[2*INDEX_W-1:INDEX_W])   == r_turn) &&
                  (cell_at(board_state, w_line_idx[INDEX_W-1:0])           == r_turn);
    w_any_empty = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (board_state[i*STATE_W +: STATE_W] == c_empty) w_any_empty = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_reject  = 1'b0;
    w_load    = 1'b0;
    w_timeout = 1'b0;
    w_win     = 1'b0;
    w_draw    = 1'b0;
    w_toggle  = 1'b0;
    w_clear   = 1'b0;
    if (new_game) begin
      w_next  = S_CLEAR;
      w_clear = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (move_valid) begin
            w_latch = 1'b1;
            w_next  = S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_illegal) begin
            w_reject = 1'b1;
            w_next   = S_IDLE;
          end else begin
            w_load = 1'b1;
            w_next = S_SUBMIT;
          end
        end
        S_SUBMIT: w_next = S_WAIT_REF;
        S_WAIT_REF: begin
          if (refresh) begin
            w_next = S_SCAN;
          end else if (r_cnt == c_cnt_w'(REF_TIMEOUT - 1)) begin
            w_timeout = 1'b1;
            w_next    = S_DONE;
          end
        end
        S_SCAN: begin
          if (w_line_win) begin
            w_win  = 1'b1;
            w_next = S_DONE;
          end else if (r_line == 3'd7) begin
            if (w_any_empty) begin
              w_toggle = 1'b1;
              w_next   = S_IDLE;
            end else begin
              w_draw = 1'b1;
              w_next = S_DONE;
            end
          end
        end
        S_DONE:  w_next = S_DONE;
        S_CLEAR: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_loc         <= '0;
      r_cnt         <= '0;
      r_line        <= '0;
      r_turn        <= c_x;
      r_winner      <= '0;
      r_game_over   <= 1'b0;
      r_fault       <= 1'b0;
      r_reject      <= 1'b0;
      r_submit      <= 1'b0;
      r_board_reset <= 1'b0;
      r_update_loc  <= '0;
      r_update_val  <= '0;
    end else begin
      r_reject      <= w_reject;
      r_submit      <= w_load;
      r_board_reset <= w_clear;
      if (w_latch) r_loc <= move_loc;
      if (r_state == S_WAIT_REF) r_cnt <= r_cnt + 1'b1;
      else                       r_cnt <= '0;
      if (r_state == S_SCAN) r_line <= r_line + 3'd1;
      else                   r_line <= '0;
      if (w_load) begin
        r_update_loc <= r_loc;
        r_update_val <= r_turn;
      end
      // Clearing on entry to CLEAR means the strobe cycle already shows a fresh game.
      if (w_clear) begin
        r_turn      <= c_x;
        r_winner    <= '0;
        r_game_over <= 1'b0;
        r_fault     <= 1'b0;
      end else begin
        if (w_toggle)  r_turn <= (r_turn == c_x) ? c_o : c_x;
        if (w_win) begin
          r_winner    <= r_turn;
          r_game_over <= 1'b1;
        end
        if (w_draw) begin
          r_winner    <= '0;
          r_game_over <= 1'b1;
        end
        if (w_timeout) r_fault <= 1'b1;
      end
    end
  end

  assign move_ready  = (r_state == S_IDLE);
  assign update_loc  = r_update_loc;
  assign update_val  = r_update_val;
  assign submit      = r_submit;
  assign board_reset = r_board_reset;
  assign turn        = r_turn;
  assign reject      = r_reject;
  assign game_over   = r_game_over;
  assign winner      = r_winner;
  assign fault       = r_fault;

endmodule
`default_nettype wire
